// File: rtl/yc_sync_sequencer.sv
// yc_sync_sequencer: colour-subcarrier phase and line-timing sequencer for Y/C video encoding
module yc_sync_sequencer #(
  parameter logic [39:0] RESET_PHASE_INC = 40'h2AAAAAAAAB,
  parameter int          CNT_MAX         = 511
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [39:0] cfg_phase_inc,
  input  logic        cfg_pal,
  input  logic        hsync,
  input  logic        vsync,
  output logic [7:0]  carrier_phase,
  output logic [7:0]  burst_phase,
  output logic        burst_gate,
  output logic        mod_gate,
  output logic        pal_flip,
  output logic [9:0]  line_count,
  output logic [1:0]  state
);

  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_SYNC, S_WAIT, S_BURST, S_ACTIVE} state_t;

  // Burst window {length, start} chosen from the carrier increment's integer part.
  function automatic logic [15:0] burst_tbl(input logic [7:0] k, input logic pal);
    return pal ? (k > 8'd56 ? {8'd85,  8'd40} :
                  k > 8'd37 ? {8'd108, 8'd40} :
                  k > 8'd28 ? {8'd130, 8'd40} :
                  k > 8'd18 ? {8'd173, 8'd60} : {8'd195, 8'd60})
               : (k > 8'd45 ? {8'd90,  8'd40} :
                  k > 8'd30 ? {8'd115, 8'd40} :
                  k > 8'd22 ? {8'd141, 8'd40} :
                  k > 8'd15 ? {8'd186, 8'd60} : {8'd211, 8'd60});
  endfunction

  localparam logic [15:0] RST_TBL = burst_tbl(RESET_PHASE_INC[39:32], 1'b0);

  logic          armed_q, hs_q, vs_q;
  logic          pend_q, pend_pal_q;
  logic [39:0]   pend_inc_q;
  logic [39:0]   act_inc_q, act_inc_d;
  logic          act_pal_q, act_pal_d;
  logic [39:0]   acc_q, acc_d;
  logic [7:0]    carrier_q, burst_q, carrier_d, offset;
  logic [7:0]    tbl_len_q, tbl_start_q;
  logic [15:0]   tbl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   cnt_w;
  state_t        state_q, state_d;
  logic          burst_gate_q, mod_gate_q;
  logic          flip_q, flip_d;
  logic [9:0]    lc_q, lc_d;
  logic          hs_rise, vs_rise, take, apply;

  // Edges are only honoured once the delayed copies hold real samples,
  // so levels present at reset release never look like an edge.
  assign hs_rise   = armed_q & hsync & ~hs_q;
  assign vs_rise   = armed_q & vsync & ~vs_q;
  assign take      = cfg_valid & ~pend_q;
  assign apply     = pend_q & vs_rise;
  assign act_inc_d = apply ? pend_inc_q : act_inc_q;
  assign act_pal_d = apply ? pend_pal_q : act_pal_q;
  assign acc_d     = apply ? 40'd0 : acc_q + act_inc_q;
  assign carrier_d = acc_q[39:32];
  assign flip_d    = (vs_rise | ~act_pal_d) ? 1'b0 : hs_rise ? ~flip_q : flip_q;
  assign offset    = ~act_pal_d ? 8'd128 : flip_d ? 8'd160 : 8'd96;
  assign lc_d      = vs_rise ? 10'd0 : (hs_rise && lc_q != 10'd1023) ? lc_q + 10'd1 : lc_q;
  assign cnt_d     = hsync ? '0 : (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + CW'(1);
  assign cnt_w     = 32'(cnt_q);
  assign tbl_d     = burst_tbl(act_inc_d[39:32], act_pal_d);

  assign cfg_ready     = ~pend_q;
  assign carrier_phase = carrier_q;
  assign burst_phase   = burst_q;
  assign burst_gate    = burst_gate_q;
  assign mod_gate      = mod_gate_q;
  assign pal_flip      = flip_q;
  assign line_count    = lc_q;
  assign state         = state_q;

  // Sync edge detectors: delayed copies plus an arm flag for the first sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      hs_q    <= hsync;
      vs_q    <= vsync;
    end
  end

  // Config slot: capture on handshake, hand over to the active set on a later vsync edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q      <= 1'b0;
      pend_inc_q  <= '0;
      pend_pal_q  <= 1'b0;
      act_inc_q   <= RESET_PHASE_INC;
      act_pal_q   <= 1'b0;
      tbl_len_q   <= RST_TBL[15:8];
      tbl_start_q <= RST_TBL[7:0];
    end else begin
      pend_q      <= take | (pend_q & ~apply);
      pend_inc_q  <= take ? cfg_phase_inc : pend_inc_q;
      pend_pal_q  <= take ? cfg_pal : pend_pal_q;
      act_inc_q   <= act_inc_d;
      act_pal_q   <= act_pal_d;
      tbl_len_q   <= tbl_d[15:8];
      tbl_start_q <= tbl_d[7:0];
    end
  end

  // Phase accumulator and the registered carrier/burst LUT indices.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      carrier_q <= 8'd0;
      burst_q   <= 8'd128;
    end else begin
      acc_q     <= acc_d;
      carrier_q <= carrier_d;
      burst_q   <= carrier_d + offset;
    end
  end

  // Line FSM next state; hsync always pulls the line back to SYNC.
  always_comb begin
    state_d = state_q;
    if (hsync) state_d = S_SYNC;
    else begin
      case (state_q)
        S_SYNC:  state_d = S_WAIT;
        S_WAIT:  state_d = (cnt_w >= 32'(tbl_start_q)) ? S_BURST : S_WAIT;
        S_BURST: state_d = (cnt_w > 32'(tbl_len_q)) ? S_ACTIVE : S_BURST;
        default: state_d = state_q;
      endcase
    end
  end

  // Line state, sample counter, gates registered from state, PAL flip and line counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_SYNC;
      cnt_q        <= '0;
      burst_gate_q <= 1'b0;
      mod_gate_q   <= 1'b0;
      flip_q       <= 1'b0;
      lc_q         <= 10'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      burst_gate_q <= state_q == S_BURST;
      mod_gate_q   <= state_q == S_ACTIVE;
      flip_q       <= flip_d;
      lc_q         <= lc_d;
    end
  end

endmodule

// File: doc/yc_sync_sequencer.md
YC_SYNC_SEQUENCER -- requirements
Module: yc_sync_sequencer

Interface
REQ-001 Parameter RESET_PHASE_INC, default 40'h2AAAAAAAAB, active carrier increment after reset (NTSC burst at 21.477 MHz).
REQ-002 Parameter CNT_MAX, default 511, saturation value of the line sample counter.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cfg_valid  in  1  new configuration offered.
REQ-006 cfg_ready  out  1  configuration slot free.
REQ-007 cfg_phase_inc  in  40  offered carrier phase increment.
REQ-008 cfg_pal  in  1  offered standard: 1 = PAL, 0 = NTSC.
REQ-009 hsync  in  1  horizontal sync, active high.
REQ-010 vsync  in  1  vertical sync, active high.
REQ-011 carrier_phase  out  8  sine-LUT index for modulation, equal to phase accumulator bits [39:32].
REQ-012 burst_phase  out  8  sine-LUT index for the colorburst.
REQ-013 burst_gate  out  1  colorburst window active.
REQ-014 mod_gate  out  1  U/V modulation window active.
REQ-015 pal_flip  out  1  PAL V-inversion for the current line.
REQ-016 line_count  out  10  lines since the last vsync rising edge.
REQ-017 state  out  2  line FSM state: 0 SYNC, 1 WAIT, 2 BURST, 3 ACTIVE.

Function
REQ-018 Config handshake: transfer occurs when cfg_valid && cfg_ready; {cfg_phase_inc, cfg_pal} are latched into a pending register, and cfg_ready drops on the next cycle.
REQ-019 Pending config is applied on the first vsync rising edge strictly after the capture cycle; cfg_ready returns to 1 on the cycle after the apply.
REQ-020 On apply, the phase accumulator clears to 0 and the burst table (REQ-023) is recomputed from the new increment; outputs use the new values from the cycle after the apply.
REQ-021 Phase accumulator: 40-bit, adds the active increment every cycle and wraps modulo 2^40; carrier_phase is registered, one cycle behind the accumulator.
REQ-022 burst_phase = carrier_phase + offset, modulo 256; offset is 128 for NTSC, 96 for PAL with pal_flip=0, and 160 for PAL with pal_flip=1.
REQ-023 Burst table, indexed by k = active_inc[39:32] (thresholds and values given NTSC/PAL), registered:
  - k > 45/56: length 90/85, start 40
  - k > 30/37: length 115/108, start 40
  - k > 22/28: length 141/130, start 40
  - k > 15/18: length 186/173, start 60
  - otherwise: length 211/195, start 60
REQ-024 Sample counter: held at 0 while hsync=1; otherwise increments by 1 per cycle and saturates at CNT_MAX.
REQ-025 FSM transitions:
  - hsync=1 forces SYNC from any state
  - SYNC -> WAIT when hsync=0
  - WAIT -> BURST when count >= start
  - BURST -> ACTIVE when count > length
  - ACTIVE holds until hsync
REQ-026 burst_gate = (state == BURST) and mod_gate = (state == ACTIVE), both registered from state.
REQ-027 pal_flip toggles on each hsync rising edge while the active standard is PAL; it is forced to 0 while NTSC.
REQ-028 line_count increments on each hsync rising edge and saturates at 1023.
REQ-029 On a vsync rising edge, line_count clears to 0 and pal_flip clears to 0; this overrides a coincident hsync rising edge.
REQ-030 Edge detection uses one-cycle-delayed copies of hsync and vsync; input levels present at reset release create no edge.
REQ-031 If the burst table gives start > length (not possible with REQ-023 values), the FSM moves from BURST to ACTIVE on the next cycle.

Reset
REQ-032 While reset_n=0, outputs take these values:
  - cfg_ready = 1; carrier_phase = 0; burst_phase = 128
  - burst_gate = 0; mod_gate = 0; pal_flip = 0
  - line_count = 0; state = SYNC
REQ-033 While reset_n=0, internal state takes these values: active config = {RESET_PHASE_INC, NTSC}; pending slot empty; accumulator = 0; counter = 0.
REQ-034 Reset asserted mid-line or mid-handshake discards any pending config; no apply occurs after reset release.

Verification
REQ-035 Reset defaults, then hsync pulse with increment 40'h2AAAAAAAAB (k=42) -> burst_gate high for counts 40..115, mod_gate high from count 116, burst_phase = carrier_phase + 128.
REQ-036 Offer cfg {40'h3800000000, PAL} mid-frame -> cfg_ready low and behaviour unchanged until the vsync rising edge; accumulator then 0; burst table is length 108, start 40 (k=56, not > 56).
REQ-037 PAL active, 4 hsync edges -> pal_flip sequence 1,0,1,0; burst_phase offset alternates 160/96; a vsync edge coincident with an hsync edge -> pal_flip 0, line_count 0.
REQ-038 cfg_valid asserted in the same cycle as a vsync rising edge -> not applied at that edge; applied at the following vsync edge.
REQ-039 1100 hsync pulses without vsync -> line_count saturates at 1023; hsync held low for 600 cycles -> counter stops at 511 and state stays ACTIVE.
REQ-040 reset_n pulsed low during BURST with a pending config -> all outputs at reset values asynchronously; after release, the next vsync does not apply the discarded config.
